// File: rtl/lsu_mem_port_if.sv
// Word-wide data memory bus between the load/store unit and memory.
//   master (LSU side): drives bus_req, bus_we, bus_addr, bus_be, bus_wdata;
//                      receives bus_ack, bus_rdata.
//   slave  (memory side): the mirror image.
// bus_req is held until bus_ack. Read data is valid in the same cycle as bus_ack.
interface lsu_mem_port_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic                  bus_ack;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port.
// Turns one core access (byte/half/word, load or store) into one or two
// word-aligned bus transactions with byte enables. Load data comes back
// aligned and sign- or zero-extended. The core stalls while busy is high.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid           access request, sampled only when busy=0
//   memWrite            1 = store, 0 = load
//   loadCtrl[2:0]       funct3 of the load (LB/LH/LW/LBU/LHU)
//   storeCtrl[1:0]      funct3[1:0] of the store (SB/SH/SW)
//   addr, wdata         byte address; right-justified store data
//   rdata, done         extended load data; one-cycle completion pulse
//   busy                access in flight
//   misalign_err        access crossed a word and splitting is disabled
//   bus                 memory bus (lsu_mem_port_if.master)
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses
// into two bus transactions. Without it, such accesses are rejected with
// misalign_err and never reach the bus.
//
// state | meaning
// IDLE  | no access; waiting for req_valid
// ACC0  | first (or only) bus transaction outstanding
// ACC1  | second word of a split access outstanding
// DONE  | done pulse; a new request may be accepted here
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  memWrite,
  input  logic [2:0]            loadCtrl,
  input  logic [1:0]            storeCtrl,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  misalign_err,
  lsu_mem_port_if.master        bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_e;

  // Lanes touched across two consecutive words: bits [3:0] are the first
  // word, [7:4] the second. The size code is shared by loads and stores
  // (00 byte, 01 half, otherwise word).
  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] ctrl, input logic [1:0] off,
                                               input logic [31:0] w1, input logic [31:0] w0);
    logic [63:0] sh;
    logic [31:0] res;
    sh = {w1, w0} >> {off, 3'b000};
    case (ctrl[1:0])
      2'b00:   res = ctrl[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = ctrl[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           word0_q, word0_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [7:0]            mask;
  logic                  split;
  logic [63:0]           wshift;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  accept;

  assign mask      = lane_mask(ctrl_q[1:0], addr_q[1:0]);
  assign split     = |mask[7:4];
  assign wshift    = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign accept    = req_valid && (state_q == IDLE || state_q == DONE);

`ifndef LSU_MISALIGN_SPLIT_EN
  logic       err_q, err_d;
  logic [7:0] in_mask;
  logic       in_split;
  assign in_mask  = lane_mask(memWrite ? storeCtrl : loadCtrl[1:0], addr[1:0]);
  assign in_split = |in_mask[7:4];
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word0_d = word0_q;
    rdata_d = rdata_q;
`ifndef LSU_MISALIGN_SPLIT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          we_d    = memWrite;
          // Store control is widened so size decoding is shared with loads.
          ctrl_d  = memWrite ? {1'b0, storeCtrl} : loadCtrl;
          addr_d  = addr;
          wdata_d = wdata;
          rdata_d = 32'b0;
          state_d = ACC0;
`ifndef LSU_MISALIGN_SPLIT_EN
          err_d   = in_split;
          if (in_split) state_d = DONE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        if (bus.bus_ack) begin
          word0_d = bus.bus_rdata;
          if (split) begin
            state_d = ACC1;
          end else begin
            // Upper word is truncated away for non-split accesses.
            rdata_d = we_q ? 32'b0 : load_extract(ctrl_q, addr_q[1:0], 32'b0, bus.bus_rdata);
            state_d = DONE;
          end
        end
      end
      ACC1: begin
        if (bus.bus_ack) begin
          rdata_d = we_q ? 32'b0 : load_extract(ctrl_q, addr_q[1:0], bus.bus_rdata, word0_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ctrl_q  <= 3'b0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      word0_q <= 32'b0;
      rdata_q <= 32'b0;
`ifndef LSU_MISALIGN_SPLIT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
`ifndef LSU_MISALIGN_SPLIT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Bus fields are functions of state and captured request only, so they
  // cannot move while a transaction waits for its ack. Idle bus reads as 0.
  always_comb begin
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_be    = 4'b0;
    bus.bus_wdata = 32'b0;
    case (state_q)
      ACC0: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = word_addr;
        bus.bus_be    = mask[3:0];
        bus.bus_wdata = wshift[31:0];
      end
      ACC1: begin
        bus.bus_req   = 1'b1;
        bus.bus_we    = we_q;
        bus.bus_addr  = word_addr + ADDR_WIDTH'(4);
        bus.bus_be    = mask[7:4];
        bus.bus_wdata = wshift[63:32];
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;
  assign done  = (state_q == DONE);
  assign busy  = (state_q == ACC0) || (state_q == ACC1);
`ifdef LSU_MISALIGN_SPLIT_EN
  assign misalign_err = 1'b0;
`else
  assign misalign_err = err_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          memWrite;
  logic [2:0]    loadCtrl;
  logic [1:0]    storeCtrl;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          done;
  logic          busy;
  logic          misalign_err;

  lsu_mem_port_if #(.ADDR_WIDTH(AW)) bus_if ();

  lsu_mem_port #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .memWrite(memWrite),
    .loadCtrl(loadCtrl), .storeCtrl(storeCtrl), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .misalign_err(misalign_err),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   passed = 0;
  int   done_cnt = 0;

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_done: got rdata=%h err=%b required no done", rdata, misalign_err);
      end else begin
        e = sb_q.pop_front();
        if (rdata !== e.rdata || misalign_err !== e.err)
          $display("FAIL sb_result: got rdata=%h err=%b required rdata=%h err=%b",
                   rdata, misalign_err, e.rdata, e.err);
        else passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input bit push);
    req_valid = 1'b1;
    memWrite  = we;
    loadCtrl  = ctrl;
    storeCtrl = ctrl[1:0];
    addr      = a;
    wdata     = wd;
    if (push) sb_q.push_back(exp_t'{rdata: er, err: ee});
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; memWrite = 1'b0; loadCtrl = 3'b0; storeCtrl = 2'b0;
    addr = '0; wdata = 32'b0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'b0;
    step(); step();
    total++; if ({bus_if.bus_req, bus_if.bus_we, done, busy, misalign_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b required 00000", {bus_if.bus_req, bus_if.bus_we, done, busy, misalign_err}); else passed++;
    total++; if (rdata !== 32'b0) $display("FAIL reset_rdata: got %h required 0", rdata); else passed++;
    total++; if (bus_if.bus_addr !== '0) $display("FAIL reset_addr: got %h required 0", bus_if.bus_addr); else passed++;
    total++; if (bus_if.bus_be !== 4'b0) $display("FAIL reset_be: got %b required 0000", bus_if.bus_be); else passed++;
    total++; if (bus_if.bus_wdata !== 32'b0) $display("FAIL reset_wdata: got %h required 0", bus_if.bus_wdata); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_aligned_lw();
    int d0 = done_cnt;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    total++; if (bus_if.bus_req !== 1'b1 || busy !== 1'b1 || bus_if.bus_we !== 1'b0)
      $display("FAIL lw_req: got req=%b busy=%b we=%b required 1 1 0", bus_if.bus_req, busy, bus_if.bus_we); else passed++;
    total++; if (bus_if.bus_addr !== 32'h100) $display("FAIL lw_addr: got %h required 00000100", bus_if.bus_addr); else passed++;
    total++; if (bus_if.bus_be !== 4'b1111) $display("FAIL lw_be: got %b required 1111", bus_if.bus_be); else passed++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEADBEEF;
    step();
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    total++; if (done !== 1'b1 || bus_if.bus_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL lw_done_cycle2: got done=%b req=%b busy=%b required 1 0 0", done, bus_if.bus_req, busy); else passed++;
    step();
    total++; if (done !== 1'b0 || rdata !== 32'hDEADBEEF)
      $display("FAIL lw_hold: got done=%b rdata=%h required 0 deadbeef", done, rdata); else passed++;
    total++; if (done_cnt !== d0 + 1) $display("FAIL lw_done_count: got %0d required %0d", done_cnt, d0 + 1); else passed++;
  endtask

  // ctrl, addr, bus word, expected be, expected rdata
  task automatic test_load_ext();
    logic [2:0]  t_ctrl[5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111};
    logic [31:0] t_addr[5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h104};
    logic [31:0] t_word[5] = '{32'h80123456, 32'h80123456, 32'h80011234, 32'h80011234, 32'hCAFEF00D};
    logic [3:0]  t_be[5]   = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1111};
    logic [31:0] t_exp[5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hCAFEF00D};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, t_ctrl[i], t_addr[i], 32'h0, t_exp[i], 1'b0, 1'b1);
      total++; if (bus_if.bus_be !== t_be[i] || bus_if.bus_addr !== {t_addr[i][31:2], 2'b00})
        $display("FAIL load_ext_bus[%0d]: got be=%b addr=%h required be=%b addr=%h", i,
                 bus_if.bus_be, bus_if.bus_addr, t_be[i], {t_addr[i][31:2], 2'b00}); else passed++;
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = t_word[i];
      step();
      bus_if.bus_ack = 1'b0;
      step();
    end
  endtask

  task automatic test_store_wait();
    issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      total++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 || bus_if.bus_be !== 4'b1100 ||
                   bus_if.bus_wdata !== 32'hABCD0000 || bus_if.bus_addr !== 32'h100 || done !== 1'b0)
        $display("FAIL sh_stable[%0d]: got req=%b we=%b be=%b wdata=%h addr=%h done=%b required 1 1 1100 abcd0000 00000100 0",
                 c, bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata, bus_if.bus_addr, done); else passed++;
      if (c == 2) bus_if.bus_ack = 1'b1;
      step();
    end
    bus_if.bus_ack = 1'b0;
    total++; if (done !== 1'b1 || bus_if.bus_req !== 1'b0)
      $display("FAIL sh_done: got done=%b req=%b required 1 0", done, bus_if.bus_req); else passed++;
    step();
  endtask

  task automatic test_split_sw();
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b1, 3'b010, 32'h101, 32'h11223344, 32'h0, 1'b0, 1'b1);
    total++; if (bus_if.bus_addr !== 32'h100 || bus_if.bus_be !== 4'b1110 || bus_if.bus_wdata !== 32'h22334400)
      $display("FAIL sw_split_first: got addr=%h be=%b wdata=%h required 00000100 1110 22334400",
               bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata); else passed++;
    bus_if.bus_ack = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;
    total++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h104 || bus_if.bus_be !== 4'b0001 ||
                 bus_if.bus_wdata !== 32'h00000011)
      $display("FAIL sw_split_second: got req=%b addr=%h be=%b wdata=%h required 1 00000104 0001 00000011",
               bus_if.bus_req, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata); else passed++;
    bus_if.bus_ack = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL sw_split_done: got %b required 1", done); else passed++;
`else
    issue(1'b1, 3'b010, 32'h101, 32'h11223344, 32'h0, 1'b1, 1'b1);
    total++; if (bus_if.bus_req !== 1'b0 || done !== 1'b1 || misalign_err !== 1'b1)
      $display("FAIL sw_misalign: got req=%b done=%b err=%b required 0 1 1", bus_if.bus_req, done, misalign_err); else passed++;
`endif
    step();
    total++; if (done !== 1'b0 || bus_if.bus_req !== 1'b0)
      $display("FAIL sw_split_after: got done=%b req=%b required 0 0", done, bus_if.bus_req); else passed++;
  endtask

  task automatic test_back_to_back();
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h66554433, 1'b0, 1'b1);
    total++; if (bus_if.bus_addr !== 32'h100 || bus_if.bus_be !== 4'b1100)
      $display("FAIL lw_split_first: got addr=%h be=%b required 00000100 1100", bus_if.bus_addr, bus_if.bus_be); else passed++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h44332211;
    step();
    total++; if (bus_if.bus_addr !== 32'h104 || bus_if.bus_be !== 4'b0011)
      $display("FAIL lw_split_second: got addr=%h be=%b required 00000104 0011", bus_if.bus_addr, bus_if.bus_be); else passed++;
    bus_if.bus_rdata = 32'h88776655;
    step();
    bus_if.bus_ack = 1'b0;
`else
    issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1'b1);
    total++; if (bus_if.bus_req !== 1'b0) $display("FAIL lw_misalign_req: got %b required 0", bus_if.bus_req); else passed++;
`endif
    total++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b required 1", done); else passed++;
    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
    total++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h200 || done !== 1'b0)
      $display("FAIL b2b_req: got req=%b addr=%h done=%b required 1 00000200 0", bus_if.bus_req, bus_if.bus_addr, done); else passed++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0BADF00D;
    step();
    bus_if.bus_ack = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL b2b_second_done: got %b required 1", done); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    total++; if (bus_if.bus_req !== 1'b1) $display("FAIL rstmid_req: got %b required 1", bus_if.bus_req); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus_if.bus_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstmid_drop: got req=%b busy=%b required 0 0", bus_if.bus_req, busy); else passed++;
    step();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFFFFFF;
    step();
    bus_if.bus_ack = 1'b0;
    step();
    total++; if (done !== 1'b0 || bus_if.bus_req !== 1'b0 || rdata !== 32'h0)
      $display("FAIL rstmid_late_ack: got done=%b req=%b rdata=%h required 0 0 0", done, bus_if.bus_req, rdata); else passed++;
    total++; if (done_cnt !== d0) $display("FAIL rstmid_done_count: got %0d required %0d", done_cnt, d0); else passed++;
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_load_ext();
    test_store_wait();
    test_split_sw();
    test_back_to_back();
    test_reset_mid();
    step();
    total++; if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d pending required 0", sb_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit between the core's control/datapath and the word-wide data memory bus. It consumes the decoded memory-write flag, the load control (`loadCtrl` = funct3) and the store control (`storeCtrl` = funct3[1:0]) produced by the main decoder. It turns one core access into one or two word-aligned bus transactions with byte enables, then returns aligned, sign- or zero-extended load data. A single-entry FSM with a req/ack handshake lets the core stall on slow memory.

## Interface
- `ADDR_WIDTH`, default 32: byte address width of the core and bus addresses.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: core access request; sampled only when `busy`=0.
- `memWrite` input 1: 1 = store, 0 = load.
- `loadCtrl` input 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are treated as LW.
- `storeCtrl` input 2: 00 SB, 01 SH, 10 SW; 11 is treated as SW.
- `addr` input ADDR_WIDTH: byte address.
- `wdata` input 32: store data, right-justified.
- `rdata` output 32: extended load data; valid when `done`=1 and held until the next acceptance.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: 1 while an access is in flight; core must stall.
- `misalign_err` output 1: valid with `done`. Can only be 1 when the macro is off.
- `bus_req` output 1: bus request; held until `bus_ack`.
- `bus_we` output 1: bus write.
- `bus_addr` output ADDR_WIDTH: word-aligned address; [1:0] is always 00.
- `bus_be` output 4: byte enables; bit n selects bits [8n+7:8n].
- `bus_wdata` output 32: lane-shifted write data.
- `bus_ack` input 1: transaction complete; read data is valid in the same cycle.
- `bus_rdata` input 32: read data.

## Operation
- **States:** IDLE, ACC0, ACC1, DONE.
- **Busy:** `busy`=0 in IDLE and DONE.
- **Acceptance:** `req_valid` is accepted at the edge while in IDLE or DONE. The unit captures `memWrite`, ctrl, `addr` and `wdata`, then goes to ACC0.
- **Access size:** 1, 2 or 4 bytes, from the control field for the operation. Let `off` = `addr[1:0]`.
- **Split condition:** an access is split when `off` + size > 4, i.e. LH/SH at off=3, or LW/SW at off≠0.
- **ACC0:**
  - `bus_req`=1, `bus_addr` = `addr` & ~3.
  - `bus_be` = lane mask of the first word.
  - `bus_wdata` = low 32 bits of ({32'b0,`wdata`} << 8·`off`).
  - On `bus_ack`: latch `bus_rdata` as word0. Go to ACC1 if split, else DONE.
- **ACC1:**
  - `bus_addr` = first address + 4, wrapping modulo 2^ADDR_WIDTH.
  - `bus_be` = remaining lanes, starting from lane 0.
  - `bus_wdata` = high 32 bits of the same 64-bit shift.
  - On `bus_ack`: latch word1 and go to DONE.
- **DONE:** `done`=1 for one cycle. Go to ACC0 if a new request is accepted, else IDLE.
- **Load result:** `rdata` = ({word1,word0} >> 8·`off`), truncated to size, then:
  - sign-extended for LB/LH;
  - zero-extended for LBU/LHU/LW.
- **Store result:** stores leave `rdata` = 0.
- **Ignored inputs:**
  - `bus_ack` in IDLE or DONE;
  - `req_valid` while `busy`=1 (no queueing).
- **Reset:** `rst` in any state forces IDLE at that edge. Any in-flight transaction is abandoned and a later `bus_ack` is ignored.

## Timing
- **Reset values:** all outputs 0.
- **Handshake:** bus outputs change only on a state transition and are stable while `bus_req`=1 without `bus_ack`.
- **Latency:**
  - Zero-wait aligned access: accepted at edge 0, `bus_req` high during cycle 1, `bus_ack` in cycle 1, `done` in cycle 2.
  - Each wait cycle adds 1.
  - A split access adds 1 cycle plus its waits.
- **Throughput:** one access per 2 cycles at best.
- **Deassertion:** `bus_req` drops in the cycle after the final ack.

## Configuration
- **Macro:** `LSU_MISALIGN_SPLIT_EN`.
- **Defined:** misaligned accesses are split as described above, and `misalign_err` is tied to 0.
- **Undefined:** an access meeting the split condition issues no bus transaction. It goes directly to DONE with `done`=1, `misalign_err`=1 and `rdata`=0, one cycle after acceptance. Aligned behaviour is identical in both builds.

## Test plan
- **Aligned LW:** LW addr 0x100, `bus_rdata` 0xDEADBEEF, immediate ack → `bus_addr` 0x100, `bus_be` 1111, `done` at cycle 2 with `rdata` 0xDEADBEEF.
- **Byte load:** LB addr 0x103, `bus_rdata` 0x80123456 → `bus_be` 1000, `rdata` 0xFFFFFF80. Same access as LBU → 0x00000080.
- **Halfword store with wait:** SH addr 0x102, `wdata` 0x0000ABCD, ack after 2 wait cycles → `bus_be` 1100, `bus_wdata` 0xABCD0000, `bus_we`=1, bus outputs stable until ack.
- **Split SW (macro on):** SW addr 0x101, `wdata` 0x11223344 → first transaction 0x100 / be 1110 / wdata 0x22334400, second 0x104 / be 0001 / wdata 0x00000011.
- **Split SW (macro off):** same SW → no `bus_req`, `misalign_err`=1.
- **Split LW:** LW addr 0x102, words 0x44332211 then 0x88776655 → `rdata` 0x66554433. Then a back-to-back LW accepted in DONE → `bus_req` high the next cycle.
- **Reset mid-access:** assert `rst` in ACC0 with ack due 3 cycles later → `bus_req`=0 in the next cycle, the late ack is ignored, and `done` stays 0.
